// File: rtl/spi_cmd_queue.sv
// rtl/spi_cmd_queue.sv - SPI master command queue with TX/RX byte FIFOs and start sequencing.
module spi_cmd_queue #(
    parameter int DEPTH = 16,
    parameter int SS_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SS_W-1:0]        cmd_ss_mask,
    input  logic [7:0]             cmd_len,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [7:0]             wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [7:0]             rd_data,
    output logic                   spi_start,
    output logic [SS_W-1:0]        spi_ss_mask,
    output logic [7:0]             spi_trans_len,
    input  logic                   spi_read,
    output logic [7:0]             spi_tx_data,
    input  logic                   spi_rx_valid,
    input  logic [7:0]             spi_rx_data,
    input  logic                   spi_busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   tx_underrun,
    output logic                   rx_overflow,
    output logic                   idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] PTR_ONE = LW'(1);
    localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    logic [7:0]      tx_mem_q [DEPTH];
    logic [7:0]      rx_mem_q [DEPTH];
    logic [AW:0]     tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic            tx_empty, tx_full, rx_empty, rx_full;
    logic            tx_push, tx_pop, rx_push, rx_pop;
    logic [AW:0]     rx_free;
    logic [7:0]      spi_tx_data_q;
    logic            tx_underrun_q, rx_overflow_q;

    logic [2:0]      state_q, state_d;
    logic [1:0]      guard_q, guard_d;
    logic [AW:0]     need_q, need_d;
    logic [SS_W-1:0] mask_q, mask_d;
    logic [7:0]      len_q, len_d;
    logic [8:0]      len_p1;

    // Pointers carry one extra wrap bit, so level MSB set means exactly full.
    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);
    assign tx_full  = tx_level[AW];
    assign rx_full  = rx_level[AW];
    assign rx_free  = DEPTH_L - rx_level;

    // Full/empty are taken before this cycle's opposite operation.
    assign tx_push = wr_valid && !tx_full;
    assign tx_pop  = spi_read && !tx_empty;
    assign rx_push = spi_rx_valid && !rx_full;
    assign rx_pop  = rd_ready && !rx_empty;

    assign wr_ready      = !tx_full;
    assign rd_valid      = !rx_empty;
    assign rd_data       = rx_mem_q[rx_rptr_q[AW-1:0]];
    assign spi_tx_data   = spi_tx_data_q;
    assign tx_underrun   = tx_underrun_q;
    assign rx_overflow   = rx_overflow_q;
    assign spi_ss_mask   = mask_q;
    assign spi_trans_len = len_q;
    assign spi_start     = (state_q == ST_START);
    assign idle          = (state_q == ST_IDLE);
    assign cmd_ready     = (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= wr_data;
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= spi_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            spi_tx_data_q <= 8'h00;
            tx_underrun_q <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
            if (spi_read) begin
                if (!tx_empty) begin
                    spi_tx_data_q <= tx_mem_q[tx_rptr_q[AW-1:0]];
                end else begin
                    spi_tx_data_q <= 8'h00;
                    tx_underrun_q <= 1'b1;
                end
            end
            if (spi_rx_valid && rx_full) rx_overflow_q <= 1'b1;
        end
    end

    assign len_p1 = {1'b0, cmd_len} + 9'd1;

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        need_d  = need_q;
        mask_d  = mask_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mask_d  = cmd_ss_mask;
                    len_d   = cmd_len;
                    need_d  = (int'(len_p1) > DEPTH) ? DEPTH_L : LW'(len_p1);
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (tx_level >= need_q && rx_free >= need_q) state_d = ST_START;
            end
            ST_START: begin
                guard_d = 2'd0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Give up if the master never reports busy within four cycles.
                if (spi_busy)              state_d = ST_RUN;
                else if (guard_q == 2'd3)  state_d = ST_IDLE;
                else                       guard_d = guard_q + 2'd1;
            end
            ST_RUN: begin
                if (!spi_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            guard_q <= 2'd0;
            need_q  <= '0;
            mask_q  <= '0;
            len_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            need_q  <= need_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_spi_cmd_queue.sv
// tb/tb_spi_cmd_queue.sv - directed and randomized self-checking bench for spi_cmd_queue.
module tb_spi_cmd_queue;
    localparam int DEPTH = 16;
    localparam int SS_W  = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready;
    logic [SS_W-1:0] cmd_ss_mask;
    logic [7:0]      cmd_len;
    logic            wr_valid, wr_ready;
    logic [7:0]      wr_data;
    logic            rd_valid, rd_ready;
    logic [7:0]      rd_data;
    logic            spi_start;
    logic [SS_W-1:0] spi_ss_mask;
    logic [7:0]      spi_trans_len;
    logic            spi_read;
    logic [7:0]      spi_tx_data;
    logic            spi_rx_valid;
    logic [7:0]      spi_rx_data;
    logic            spi_busy;
    logic [4:0]      tx_level, rx_level;
    logic            tx_underrun, rx_overflow, idle;

    always #5 clk = ~clk;

    spi_cmd_queue #(.DEPTH(DEPTH), .SS_W(SS_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ss_mask(cmd_ss_mask), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .spi_start(spi_start), .spi_ss_mask(spi_ss_mask), .spi_trans_len(spi_trans_len),
        .spi_read(spi_read), .spi_tx_data(spi_tx_data),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_busy(spi_busy),
        .tx_level(tx_level), .rx_level(rx_level),
        .tx_underrun(tx_underrun), .rx_overflow(rx_overflow), .idle(idle)
    );

    int         errors = 0;
    int         checks = 0;
    int         start_count = 0;
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [7:0] rx_src[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_tx_data;
    logic       exp_under, exp_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (spi_start === 1'b1) start_count++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 0; wr_valid = 0; rd_ready = 0; spi_read = 0;
        spi_rx_valid = 0; spi_busy = 0;
        cmd_ss_mask = '0; cmd_len = 8'h00; wr_data = 8'h00; spi_rx_data = 8'h00;
        cycle();
        cycle();
        rst = 1'b0;
        tx_m.delete(); rx_m.delete(); got_q.delete();
        exp_tx_data = 8'h00; exp_under = 0; exp_over = 0;
        start_count = 0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        wr_valid = 1'b1; wr_data = b;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic accept(input logic [SS_W-1:0] m, input logic [7:0] l);
        cmd_valid = 1'b1; cmd_ss_mask = m; cmd_len = l;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (spi_start === 1'b1) begin ok = 1; break; end
            cycle();
        end
        check("start_seen", ok, 1);
    endtask

    // Bus model: busy for busy_len cycles, one read/rx byte per cycle for nbytes.
    task automatic bus_xfer(input int nbytes, input int busy_len);
        bit ok = 0;
        spi_busy = 1'b1;
        cycle();
        for (int i = 0; i < busy_len; i++) begin
            if (i < nbytes) begin
                spi_read = 1'b1; spi_rx_valid = 1'b1; spi_rx_data = rx_src[i];
                cycle();
                spi_read = 1'b0; spi_rx_valid = 1'b0;
                got_q.push_back(spi_tx_data);
            end else begin
                cycle();
            end
        end
        spi_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (idle === 1'b1) begin ok = 1; break; end
        end
        check("idle_after_busy", ok, 1);
    endtask

    initial begin
        bit wv, rr, sr, rv, txf, txe, rxf, rxe;
        logic [7:0] wd, rxd;
        int p;

        // Reset state and single-byte transfer
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_start", spi_start, 0);
        check("rst_mask", spi_ss_mask, 0);
        check("rst_len", spi_trans_len, 0);
        check("rst_tx_data", spi_tx_data, 0);
        check("rst_flags", {tx_underrun, rx_overflow}, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        push_tx(8'hA5);
        check("a_tx_level", tx_level, 1);
        accept(24'd4, 8'd0);
        check("a_cmd_ready", cmd_ready, 0);
        check("a_mask", spi_ss_mask, 4);
        check("a_len", spi_trans_len, 0);
        wait_start();
        rx_src = '{8'h00};
        bus_xfer(1, 20);
        check("a_start_once", start_count, 1);
        check("a_tx_byte", got_q[0], 8'hA5);
        check("a_tx_hold", spi_tx_data, 8'hA5);
        check("a_mask_hold", spi_ss_mask, 4);

        // Four-byte transfer with RX return
        do_reset();
        push_tx(8'hFF); push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h5A);
        check("b_tx_level", tx_level, 4);
        accept(24'd8, 8'd3);
        wait_start();
        rx_src = '{8'h33, 8'hAA, 8'h55, 8'hFF};
        bus_xfer(4, 6);
        check("b_tx0", got_q[0], 8'hFF);
        check("b_tx1", got_q[1], 8'hA5);
        check("b_tx2", got_q[2], 8'h3C);
        check("b_tx3", got_q[3], 8'h5A);
        check("b_rx_level", rx_level, 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b_rd_data", rd_data, rx_src[i]);
            cycle();
        end
        rd_ready = 1'b0;
        check("b_tx_level_end", tx_level, 0);
        check("b_rx_level_end", rx_level, 0);
        check("b_rd_valid", rd_valid, 0);
        check("b_start_once", start_count, 1);

        // Start held off until enough TX data, then the busy guard expires
        do_reset();
        push_tx(8'h10); push_tx(8'h11);
        accept(24'd1, 8'd3);
        for (int i = 0; i < 10; i++) cycle();
        check("c_no_start_early", start_count, 0);
        push_tx(8'h12); push_tx(8'h13);
        wait_start();
        check("c_tx_level_at_start", tx_level, 4);
        for (int i = 0; i < 4; i++) cycle();
        check("c_guard_not_yet", idle, 0);
        cycle();
        check("c_guard_idle", idle, 1);
        check("c_start_once", start_count, 1);

        // TX full, simultaneous push/read, underrun
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wd = 8'($urandom);
            tx_m.push_back(wd);
            push_tx(wd);
        end
        check("d_full_level", tx_level, 16);
        check("d_wr_ready", wr_ready, 0);
        check("d_no_underrun", tx_underrun, 0);
        wr_valid = 1'b1; wr_data = 8'hEE; spi_read = 1'b1;
        cycle();
        wr_valid = 1'b0; spi_read = 1'b0;
        check("d_level_15", tx_level, 15);
        check("d_tx_data", spi_tx_data, tx_m.pop_front());
        for (int i = 0; i < DEPTH - 1; i++) begin
            spi_read = 1'b1;
            cycle();
            check("d_drain", spi_tx_data, tx_m.pop_front());
        end
        wr_valid = 1'b1; wr_data = 8'h77;
        cycle();
        spi_read = 1'b0; wr_valid = 1'b0;
        check("d_underrun_data", spi_tx_data, 0);
        check("d_underrun", tx_underrun, 1);
        check("d_push_kept", tx_level, 1);

        // RX full, overflow with simultaneous pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rxd = 8'($urandom);
            rx_m.push_back(rxd);
            spi_rx_valid = 1'b1; spi_rx_data = rxd;
            cycle();
        end
        spi_rx_valid = 1'b0;
        check("e_rx_full", rx_level, 16);
        check("e_head", rd_data, rx_m[0]);
        spi_rx_valid = 1'b1; spi_rx_data = 8'h77; rd_ready = 1'b1;
        cycle();
        spi_rx_valid = 1'b0; rd_ready = 1'b0;
        void'(rx_m.pop_front());
        check("e_rx_level", rx_level, 15);
        check("e_overflow", rx_overflow, 1);
        check("e_next_head", rd_data, rx_m[0]);

        // Reset during RUN
        do_reset();
        push_tx(8'h5A);
        accept(24'hABCDEF, 8'd0);
        wait_start();
        spi_busy = 1'b1;
        cycle(); cycle(); cycle();
        check("f_busy_run", idle, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("f_cmd_ready", cmd_ready, 1);
        check("f_levels", {tx_level, rx_level}, 0);
        check("f_outputs", {spi_start, spi_ss_mask, spi_trans_len, spi_tx_data}, 0);
        for (int i = 0; i < 5; i++) cycle();
        spi_busy = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("f_no_restart", start_count, 1);
        check("f_still_idle", idle, 1);

        // Randomized FIFO traffic against queue model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            p  = (i < 200) ? 75 : ((i < 400) ? 25 : 50);
            wv = ($urandom_range(0, 99) < p);
            rv = ($urandom_range(0, 99) < p);
            sr = ($urandom_range(0, 99) < 100 - p);
            rr = ($urandom_range(0, 99) < 100 - p);
            wd = 8'($urandom); rxd = 8'($urandom);
            wr_valid = wv; wr_data = wd; spi_read = sr;
            spi_rx_valid = rv; spi_rx_data = rxd; rd_ready = rr;
            txf = (tx_m.size() == DEPTH); txe = (tx_m.size() == 0);
            rxf = (rx_m.size() == DEPTH); rxe = (rx_m.size() == 0);
            if (sr) begin
                if (!txe) exp_tx_data = tx_m.pop_front();
                else begin exp_tx_data = 8'h00; exp_under = 1; end
            end
            if (wv && !txf) tx_m.push_back(wd);
            if (rr && !rxe) void'(rx_m.pop_front());
            if (rv) begin
                if (!rxf) rx_m.push_back(rxd);
                else exp_over = 1;
            end
            cycle();
            check("r_tx_level", tx_level, tx_m.size());
            check("r_rx_level", rx_level, rx_m.size());
            check("r_wr_ready", wr_ready, tx_m.size() != DEPTH);
            check("r_rd_valid", rd_valid, rx_m.size() != 0);
            if (rx_m.size() != 0) check("r_rd_data", rd_data, rx_m[0]);
            check("r_tx_data", spi_tx_data, exp_tx_data);
            check("r_underrun", tx_underrun, exp_under);
            check("r_overflow", rx_overflow, exp_over);
            check("r_idle", idle, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_cmd_queue.md
SPI_CMD_QUEUE -- requirements
Module: spi_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 16, shall set the TX and RX FIFO depth in bytes; it shall be a power of two and at least 2.
REQ-002 Parameter SS_W, default 24, shall set the slave-select mask width.
REQ-003 Port clk, input, 1, shall be the single clock; all logic updates on its rising edge.
REQ-004 Port rst, input, 1, shall be the reset: synchronous, active-high.
REQ-005 Port cmd_valid, input, 1, shall signal that a command is offered.
REQ-006 Port cmd_ready, output, 1, shall signal that a command can be accepted.
REQ-007 Port cmd_ss_mask, input, SS_W, shall give the slave-select mask for the command.
REQ-008 Port cmd_len, input, 8, shall give the transfer length as byte count minus 1.
REQ-009 Ports wr_valid/wr_ready (in/out, 1) and wr_data (in, 8) shall form the TX-byte push handshake.
REQ-010 Ports rd_valid/rd_ready (out/in, 1) and rd_data (out, 8) shall form the RX-byte pop handshake.
REQ-011 Ports spi_start (out, 1), spi_ss_mask (out, SS_W) and spi_trans_len (out, 8) shall drive the master's command inputs.
REQ-012 Ports spi_read (in, 1) and spi_tx_data (out, 8) shall carry the master's TX-byte request and the data returned to it.
REQ-013 Ports spi_rx_valid (in, 1), spi_rx_data (in, 8) and spi_busy (in, 1) shall receive the master's RX bytes and status.
REQ-014 Ports tx_level and rx_level (out, $clog2(DEPTH)+1 each), tx_underrun and rx_overflow (out, 1, sticky), and idle (out, 1) shall report status.

Function
REQ-015 The TX and RX FIFOs shall be synchronous, non-fall-through and power-of-two wrapped; the level of each shall equal pushes minus pops.
REQ-016 wr_ready shall equal !tx_full; a push shall occur only on wr_valid && wr_ready.
REQ-017 rd_valid shall equal !rx_empty and rd_data shall show the head entry combinationally; a pop shall occur on rd_valid && rd_ready.
REQ-018 A push and a pop in the same cycle shall leave the level unchanged.
REQ-019 The FSM states shall be IDLE, WAIT_DATA, START, WAIT_BUSY and RUN, and idle shall equal (state==IDLE).
REQ-020 cmd_ready shall equal (state==IDLE).
REQ-021 On cmd_valid && cmd_ready, the block shall latch the mask and length into spi_ss_mask and spi_trans_len, hold them until the next accept, and go to WAIT_DATA.
REQ-022 Let N = min(cmd_len+1, DEPTH); WAIT_DATA shall go to START in the first cycle where tx_level >= N and (DEPTH - rx_level) >= N.
REQ-023 START shall assert spi_start for exactly one cycle and then go to WAIT_BUSY.
REQ-024 WAIT_BUSY shall go to RUN when spi_busy=1, or to IDLE if spi_busy stays 0 for 4 cycles (guard).
REQ-025 RUN shall go to IDLE in the cycle after spi_busy is first sampled 0.
REQ-026 On a cycle with spi_read=1 and the TX FIFO non-empty, the block shall pop the TX FIFO and register the popped byte into spi_tx_data, valid from the next cycle and held until the next spi_read.
REQ-027 On spi_read=1 with the TX FIFO empty, spi_tx_data shall become 8'h00 and tx_underrun shall set; a same-cycle wr push shall not satisfy that read.
REQ-028 On spi_rx_valid=1, the block shall push spi_rx_data into the RX FIFO; if the FIFO is full, the byte shall be dropped and rx_overflow shall set.
REQ-029 A same-cycle rd pop on a full RX FIFO shall not make room for that push.
REQ-030 spi_read and spi_rx_valid shall be honoured in every state, not only in RUN.
REQ-031 cmd_len=255 with DEPTH=16 shall start at 16 buffered bytes; further TX bytes shall stream in during RUN.

Reset
REQ-032 While rst=1 at a rising edge, the block shall set state IDLE, empty both FIFOs, and clear both levels, spi_start, spi_ss_mask, spi_trans_len, spi_tx_data, tx_underrun and rx_overflow to 0.
REQ-033 Reset asserted mid-transfer shall abort immediately, with no further spi_start pulse; cmd_ready shall be 1 in the first cycle after rst deasserts.
REQ-034 Sticky flags shall clear only on rst.

Verification
REQ-035 Push A5; accept mask=4, len=0; bus model sets busy for 20 cycles and issues one read -> one spi_start pulse, spi_tx_data=A5, idle again after busy falls.
REQ-036 Push 4 bytes FF,A5,3C,5A; accept mask=8, len=3; model returns rx 33,AA,55,FF -> TX FIFO drains in order, then rd pops 33,AA,55,FF, tx_level=rx_level=0.
REQ-037 Accept len=3 with only 2 TX bytes, then push 2 more 10 cycles later -> spi_start held 0 until tx_level=4, then pulses once.
REQ-038 Fill TX to 16 -> wr_ready=0; a simultaneous push and spi_read -> tx_level becomes 15; spi_read on an empty FIFO -> spi_tx_data=00, tx_underrun=1.
REQ-039 Fill RX to 16, then spi_rx_valid with rd_ready=1 -> byte dropped, rx_overflow=1, rx_level=15.
REQ-040 Assert rst during RUN -> all outputs 0, levels 0, cmd_ready=1 the next cycle; no spi_start is issued.
